// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one UART transmit channel among NUM_REQ producers.
// Optional per-requester byte counters are enabled by defining UART_ARB_STATS_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_data,
  output logic                       uart_valid,
  input  logic                       uart_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  input  logic                       stat_clr,
  output logic [CNT_WIDTH-1:0]       stat_count
);

  localparam int unsigned IDXW       = $clog2(NUM_REQ);
  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0]  IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     gidx_q, gidx_d;
  logic [IDXW-1:0]     rr_q, rr_d;
  logic [7:0]          burst_q, burst_d;
  logic [7:0]          idle_q, idle_d;

  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic                own_valid, own_last;
  logic [7:0]          own_data;
  logic                xfer, release_now;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned     cand;
      logic [IDXW-1:0] cand_idx;
      cand     = (32'(rr_q) + k) % NUM_REQ;
      cand_idx = cand[IDXW-1:0];
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDXW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign busy        = (state_q == S_GRANT);
  assign grant       = grant_q;
  assign xfer        = busy && own_valid && uart_ready;
  assign release_now = (xfer && (own_last || burst_q == BURST_LAST)) ||
                       (busy && !own_valid && idle_q == IDLE_LAST);

  always_comb begin
    uart_data  = '0;
    uart_valid = 1'b0;
    req_ready  = '0;
    if (busy) begin
      uart_data  = own_data;
      uart_valid = own_valid;
      req_ready  = grant_q & {NUM_REQ{uart_ready}};
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          burst_d           = '0;
          idle_d            = '0;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          burst_d = burst_q + 8'd1;
          idle_d  = '0;
        end else if (!own_valid) begin
          idle_d = idle_q + 8'd1;
        end
        // Last and burst cap on the same byte fold into this single release.
        if (release_now) begin
          state_d = S_IDLE;
          grant_d = '0;
          rr_d    = gidx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IDXW'(NUM_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)
        cnt_d[i] = '0;
      else if (xfer && gidx_q == IDXW'(i))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Selects beyond NUM_REQ match no entry and read zero.
  always_comb begin
    stat_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (stat_sel == IDXW'(i)) stat_count = cnt_q[i];
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_count  = '0;
`endif

endmodule
